// File: rtl/md_unit_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Holds funct3 op codes, FSM state encoding and operand-signedness helpers.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_FIN  = 2'd2
  } md_state_e;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    logic v;
    case (op)
      MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM: v = 1'b1;
      default:                                                  v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    logic v;
    case (op)
      MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM: v = 1'b1;
      default:                                     v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide subtract/restore step on the {hi, lo} register pair.
module md_step
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Extra top bit keeps the multiply carry and the divide borrow
  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opd} : {(WIDTH+1){1'b0}});
  assign w_shift = {i_hi, i_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_opd};

  // Select the multiply or divide update for this iteration
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_div) begin
      if (!w_diff[WIDTH]) begin
        o_hi = w_diff[WIDTH-1:0];
      end else begin
        o_hi = w_shift[WIDTH-1:0];
      end
      o_lo = {i_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Magnitudes are computed over WIDTH iterations and sign-corrected in FIN.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [2:0]       r_op;
  logic             r_sign;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_fast;
  logic             w_sign;
  logic             w_ld;
  logic             w_step;
  logic             w_fin;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_c;
  logic [WIDTH-1:0] w_res;

  // Operand magnitudes, result sign and divide special-case detection
  always_comb begin
    w_a_neg  = op_a_signed(op) & a[WIDTH-1];
    w_b_neg  = op_b_signed(op) & b[WIDTH-1];
    w_a_abs  = w_a_neg ? (~a + ONE_W) : a;
    w_b_abs  = w_b_neg ? (~b + ONE_W) : b;
    w_b_zero = (b == ZERO_W);
    w_ovf    = ((op == MD_OP_DIV) || (op == MD_OP_REM)) && (a == MIN_W) && (b == ONES_W);
    w_fast   = op[2] & (w_b_zero | w_ovf);
    case (op)
      MD_OP_REM:                           w_sign = w_a_neg;
      MD_OP_MULHU, MD_OP_DIVU, MD_OP_REMU: w_sign = 1'b0;
      default:                             w_sign = w_a_neg ^ w_b_neg;
    endcase
  end

  md_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_div (r_op[2]),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_opd (r_opd),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MD_STATE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; flush aborts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = MD_STATE_IDLE;
    end else begin
      case (r_state)
        MD_STATE_IDLE: begin
          if (start) begin
            w_state_nxt = w_fast ? MD_STATE_FIN : MD_STATE_CALC;
          end else begin
            w_state_nxt = MD_STATE_IDLE;
          end
        end
        MD_STATE_CALC: begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = MD_STATE_FIN;
          end else begin
            w_state_nxt = MD_STATE_CALC;
          end
        end
        MD_STATE_FIN: w_state_nxt = MD_STATE_IDLE;
        default:      w_state_nxt = MD_STATE_IDLE;
      endcase
    end
  end

  // FSM output decode: load, iterate and finish strobes
  always_comb begin
    w_ld   = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    if (flush) begin
      w_ld   = 1'b0;
      w_step = 1'b0;
      w_fin  = 1'b0;
    end else begin
      case (r_state)
        MD_STATE_IDLE: w_ld   = start;
        MD_STATE_CALC: w_step = 1'b1;
        MD_STATE_FIN:  w_fin  = 1'b1;
        default:       w_ld   = 1'b0;
      endcase
    end
  end

  // Sign correction and result selection applied in FIN
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_c = r_sign ? (~w_prod + ONE_2W) : w_prod;
    case (r_op)
      MD_OP_MUL:                             w_res = w_prod_c[WIDTH-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: w_res = w_prod_c[2*WIDTH-1:WIDTH];
      MD_OP_DIV, MD_OP_DIVU:                 w_res = r_sign ? (~r_lo + ONE_W) : r_lo;
      MD_OP_REM, MD_OP_REMU:                 w_res = r_sign ? (~r_hi + ONE_W) : r_hi;
      default:                               w_res = ZERO_W;
    endcase
  end

  // Datapath registers: lo holds multiplier/dividend, hi accumulates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= MD_OP_MUL;
      r_sign <= 1'b0;
      r_hi   <= ZERO_W;
      r_lo   <= ZERO_W;
      r_opd  <= ZERO_W;
      r_cnt  <= ZERO_CNT;
    end else if (w_ld) begin
      r_op  <= op;
      r_cnt <= ZERO_CNT;
      if (w_fast) begin
        // Pre-computed: quotient in lo, remainder in hi, no sign fix
        r_sign <= 1'b0;
        r_opd  <= ZERO_W;
        r_hi   <= w_b_zero ? a : ZERO_W;
        r_lo   <= w_b_zero ? ONES_W : a;
      end else if (op[2]) begin
        r_sign <= w_sign;
        r_opd  <= w_b_abs;
        r_hi   <= ZERO_W;
        r_lo   <= w_a_abs;
      end else begin
        r_sign <= w_sign;
        r_opd  <= w_a_abs;
        r_hi   <= ZERO_W;
        r_lo   <= w_b_abs;
      end
    end else if (w_step) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + ONE_CNT;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Registered handshake outputs and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ZERO_W;
    end else if (flush) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_ld) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_fin) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b1;
      r_result <= w_res;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts the operand pair and an M-extension op through a start/busy/done handshake.
- Runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles.
- Holds the result until the next start.
- The hazard unit stalls IF/ID/EX while busy is high and writes result back when done pulses.

Parameters:
WIDTH, 32 (`WORD_LEN), operand and result width; must be even and at least 8.
CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
clk     input   1       clock; all state updates on the rising edge
rst     input   1       asynchronous, active-high reset
start   input   1       request; sampled only when busy=0
op      input   3       funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a       input   WIDTH   rs1 operand; sampled with start
b       input   WIDTH   rs2 operand; sampled with start
flush   input   1       abort from branch/exception; has priority over start
busy    output  1       operation in progress; start is ignored while high
done    output  1       one-cycle pulse; result is valid from this cycle on
result  output  WIDTH   registered result; holds its value until the next accepted start

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIN.
- IDLE with start=1 and flush=0, at edge E0:
  - Latch op.
  - Latch |a| and |b| for signed operands (MULH: both signed; MULHSU: a only; DIV/REM: both).
  - Record the result sign: XOR of the operand signs for MUL-family and DIV; the sign of a for REM.
  - Clear the accumulator and set counter=0.
  - busy=1 and next state is CALC.
- Fast path, taken at E0 instead of entering CALC. Next state is FIN with the result pre-computed.
  - b=0 on a divide op: quotient = all ones; remainder = a.
  - op=DIV/REM with a=-2^(WIDTH-1) and b=-1: quotient = a; remainder = 0.
- CALC, one iteration per edge, for exactly WIDTH edges (E1..E_WIDTH).
  - Transition to FIN on the edge where counter=WIDTH-1.
  - Multiply step: if the multiplier LSB is set, add the multiplicand to the upper half of the 2*WIDTH product; then shift right one bit.
  - Divide step: shift the remainder left, bringing in the next dividend MSB. Subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore and set it to 0.
- FIN, one edge (E_WIDTH+1):
  - Apply two's-complement sign correction.
  - Select the result: MUL takes the low half; MULH/MULHSU/MULHU take the high half; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register result, set done=1 and busy=0, and return to IDLE.
- Latency from the start edge to the first done-high cycle:
  - normal path: WIDTH+2 edges (34 for WIDTH=32);
  - fast path: 2 edges.
- done is high for exactly one cycle.
- A start arriving in that same cycle (busy=0) is accepted, giving back-to-back operation.
- start while busy=1 is ignored: no queuing, no error.
- flush=1 in any state: next state is IDLE, busy=0, done=0, result unchanged. flush and start together in IDLE means no operation is accepted.
- Asynchronous reset mid-operation discards all work and forces reset values immediately.
- All arithmetic is modulo 2^WIDTH. MULHSU treats b as unsigned. The internal product/accumulator width is 2*WIDTH (+1 bit for the divide subtract).

Decomposition:
- defines.v gains:
  - `MD_OP_MUL .. `MD_OP_REMU (3-bit funct3 codes);
  - `MD_STATE_IDLE/CALC/FIN;
  - `FUNCT7_MULDIV (7'b0000001) for the decoder.
- One single-file module.
- The per-iteration datapath step may be split into the combinational sub-module md_step (one multiply-add or subtract/restore). Everything else stays in md_unit.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at edge 34, result=0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV/REM a=5, b=0 -> 0xFFFFFFFF/5, done at edge 2. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- start pulsed at cycle 10 of a running DIV -> ignored, original result correct. start in the done cycle -> second op accepted and completes 34 edges later.
- flush at CALC iteration 15 -> busy=0 next cycle, no done, result keeps its prior value. Async rst mid-CALC -> all outputs 0 immediately.
